oars_scroll_driver: RTL and testbench

//   Clocked generator for the six-digit scrolling "OARS" banner on HEX0..HEX5.
//   A six-entry ring of character codes rotates one position per prescaled tick,
//   or per single-step request, and is decoded to active-low 7-segment patterns.
//   It is the transmitting end of the HEX display interface.
//   The display-decoding bench reads these outputs and recovers the banner text.

---
 rtl/oars_scroll_driver.sv | 126 ++++++++++++
 tb/tb_oars_scroll_driver.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/oars_scroll_driver.sv
// Six-digit scrolling "OARS" banner generator: a rotating ring of 3-bit
// character codes decoded to active-low 7-segment patterns on HEX0..HEX5.
module oars_scroll_driver #(
   parameter int TICK_DIV = 50000000
) (
   input  logic       Clock,
   input  logic       Reset,
   input  logic       En,
   input  logic       Dir,
   input  logic       Step,
   input  logic       Load,
   output logic [0:6] HEX0,
   output logic [0:6] HEX1,
   output logic [0:6] HEX2,
   output logic [0:6] HEX3,
   output logic [0:6] HEX4,
   output logic [0:6] HEX5,
   output logic [2:0] Pos
);

   localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

   localparam logic [2:0] C_BLANK = 3'd0;
   localparam logic [2:0] C_O     = 3'd1;
   localparam logic [2:0] C_A     = 3'd2;
   localparam logic [2:0] C_R     = 3'd3;
   localparam logic [2:0] C_S     = 3'd4;

   function automatic logic [2:0] f_default(input int idx);
      logic [2:0] code;
      case (idx)
         1:       code = C_O;
         2:       code = C_A;
         3:       code = C_R;
         4:       code = C_S;
         default: code = C_BLANK;
      endcase
      return code;
   endfunction

   // Segment order a..g, active-low; unused codes stay dark.
   function automatic logic [0:6] f_decode(input logic [2:0] code);
      logic [0:6] seg;
      case (code)
         C_O:     seg = 7'b0000001;
         C_A:     seg = 7'b0001000;
         C_R:     seg = 7'b1111010;
         C_S:     seg = 7'b0100100;
         default: seg = 7'b1111111;
      endcase
      return seg;
   endfunction

   logic [2:0]       r_ring [0:5];
   logic [2:0]       r_pos;
   logic [CNT_W-1:0] r_cnt;
   logic             r_step_q;

   logic [2:0]       w_shift [0:5];
   logic [0:6]       w_seg   [0:5];
   logic             w_tick;
   logic             w_step_pulse;
   logic             w_advance;
   logic [2:0]       w_pos_next;

   assign w_tick       = En && (r_cnt == CNT_LAST);
   assign w_step_pulse = Step && !r_step_q && !En;
   assign w_advance    = w_tick || w_step_pulse;

   always_comb begin
      w_pos_next = r_pos;
      if (Dir) begin
         w_pos_next = (r_pos == 3'd0) ? 3'd5 : r_pos - 3'd1;
      end else begin
         w_pos_next = (r_pos == 3'd5) ? 3'd0 : r_pos + 3'd1;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < 6; gi++) begin : g_digit
         localparam int PREV = (gi + 5) % 6;
         localparam int NEXT = (gi + 1) % 6;
         assign w_shift[gi] = Dir ? r_ring[NEXT] : r_ring[PREV];
         assign w_seg[gi]   = f_decode(r_ring[gi]);
      end
   endgenerate

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         for (int i = 0; i < 6; i++) r_ring[i] <= f_default(i);
         r_pos    <= 3'd0;
         r_cnt    <= '0;
         r_step_q <= 1'b0;
      end else begin
         // Edge register tracks Step even while running, so a held Step
         // cannot produce a late shift when En falls.
         r_step_q <= Step;
         if (Load) begin
            for (int i = 0; i < 6; i++) r_ring[i] <= f_default(i);
            r_pos <= 3'd0;
            r_cnt <= '0;
         end else begin
            if (!En || w_tick) begin
               r_cnt <= '0;
            end else begin
               r_cnt <= r_cnt + 1'b1;
            end
            if (w_advance) begin
               for (int i = 0; i < 6; i++) r_ring[i] <= w_shift[i];
               r_pos <= w_pos_next;
            end
         end
      end
   end

   assign HEX0 = w_seg[0];
   assign HEX1 = w_seg[1];
   assign HEX2 = w_seg[2];
   assign HEX3 = w_seg[3];
   assign HEX4 = w_seg[4];
   assign HEX5 = w_seg[5];
   assign Pos  = r_pos;

endmodule

// File: tb/tb_oars_scroll_driver.sv
// Scoreboard bench for oars_scroll_driver with TICK_DIV=4: a cycle model pushes
// the expected display word each clock, compared one clock later after the edge.
module tb_oars_scroll_driver;

   localparam int TD = 4;

   logic       Clock = 1'b0;
   logic       Reset;
   logic       En, Dir, Step, Load;
   logic [0:6] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
   logic [2:0] Pos;

   oars_scroll_driver #(.TICK_DIV(TD)) dut (
      .Clock(Clock), .Reset(Reset), .En(En), .Dir(Dir), .Step(Step), .Load(Load),
      .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3), .HEX4(HEX4), .HEX5(HEX5),
      .Pos(Pos)
   );

   always #5 Clock = ~Clock;

   int n_checks = 0;
   int n_errors = 0;

   logic [2:0]  m_ring [6];
   logic [2:0]  m_pos;
   int          m_cnt;
   logic        m_stepq;
   logic [44:0] sb_q [$];

   // Codes: 0 blank, 1 O, 2 A, 3 R, 4 S
   function automatic logic [6:0] seg(input logic [2:0] c);
      case (c)
         3'd1:    return 7'b0000001;
         3'd2:    return 7'b0001000;
         3'd3:    return 7'b1111010;
         3'd4:    return 7'b0100100;
         default: return 7'b1111111;
      endcase
   endfunction

   function automatic logic [44:0] word_of(input int c0, c1, c2, c3, c4, c5, p);
      return {seg(3'(c0)), seg(3'(c1)), seg(3'(c2)), seg(3'(c3)), seg(3'(c4)), seg(3'(c5)), 3'(p)};
   endfunction

   function automatic logic [44:0] model_word();
      return {seg(m_ring[0]), seg(m_ring[1]), seg(m_ring[2]),
              seg(m_ring[3]), seg(m_ring[4]), seg(m_ring[5]), m_pos};
   endfunction

   function automatic logic [44:0] dut_word();
      return {HEX0, HEX1, HEX2, HEX3, HEX4, HEX5, Pos};
   endfunction

   task automatic check(input string tag, input logic [44:0] got, input logic [44:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_ring[0] = 3'd0; m_ring[1] = 3'd1; m_ring[2] = 3'd2;
      m_ring[3] = 3'd3; m_ring[4] = 3'd4; m_ring[5] = 3'd0;
      m_pos = 3'd0; m_cnt = 0; m_stepq = 1'b0;
   endtask

   task automatic model_step();
      logic       tick, pulse;
      logic [2:0] old [6];
      tick  = En && (m_cnt == TD - 1);
      pulse = Step && !m_stepq && !En;
      m_stepq = Step;
      if (Load) begin
         model_reset();
         m_stepq = Step;
      end else begin
         m_cnt = (!En || tick) ? 0 : m_cnt + 1;
         if (tick || pulse) begin
            for (int i = 0; i < 6; i++) old[i] = m_ring[i];
            if (!Dir) begin
               for (int i = 0; i < 6; i++) m_ring[(i + 1) % 6] = old[i];
               m_pos = (m_pos == 3'd5) ? 3'd0 : m_pos + 3'd1;
            end else begin
               for (int i = 0; i < 6; i++) m_ring[i] = old[(i + 1) % 6];
               m_pos = (m_pos == 3'd0) ? 3'd5 : m_pos - 3'd1;
            end
         end
      end
   endtask

   // Inputs are stable before the edge; the model advances, the expectation is
   // queued, and the DUT is compared 1 time unit after the edge.
   task automatic cycle(input string tag);
      model_step();
      sb_q.push_back(model_word());
      @(posedge Clock);
      #1;
      check(tag, dut_word(), sb_q.pop_front());
   endtask

   task automatic cycles(input string tag, input int n);
      for (int k = 0; k < n; k++) cycle(tag);
   endtask

   // Asynchronous reset between edges, checked before any clock arrives.
   task automatic async_reset(input string tag);
      #2;
      Reset = 1'b1;
      model_reset();
      sb_q.push_back(model_word());
      #1;
      check(tag, dut_word(), sb_q.pop_front());
      @(posedge Clock);
      #1;
      check({tag, "_hold"}, dut_word(), word_of(0, 1, 2, 3, 4, 0, 0));
      Reset = 1'b0;
   endtask

   initial begin
      Reset = 1'b1; En = 1'b0; Dir = 1'b0; Step = 1'b0; Load = 1'b0;
      model_reset();

      // 1: reset with no clock edge yet
      #2;
      sb_q.push_back(model_word());
      check("reset_noclk", dut_word(), sb_q.pop_front());
      check("reset_const", dut_word(), word_of(0, 1, 2, 3, 4, 0, 0));
      @(posedge Clock);
      #1;
      Reset = 1'b0;

      // 2: free-run toward HEX5
      En = 1'b1; Dir = 1'b0;
      cycles("run_d0", 4);
      check("run_d0_first", dut_word(), word_of(0, 0, 1, 2, 3, 4, 1));
      cycles("run_d0", 20);
      check("run_d0_wrap", dut_word(), word_of(0, 1, 2, 3, 4, 0, 0));

      // 3: free-run toward HEX0 from reset
      async_reset("rst_a");
      En = 1'b1; Dir = 1'b1;
      cycles("run_d1", 4);
      check("run_d1_first", dut_word(), word_of(1, 2, 3, 4, 0, 0, 5));
      cycles("run_d1", 20);
      check("run_d1_wrap", dut_word(), word_of(0, 1, 2, 3, 4, 0, 0));

      // 4: single step, held Step gives one shift
      async_reset("rst_b");
      En = 1'b0; Dir = 1'b0; Step = 1'b1;
      cycles("step_hold", 10);
      check("step_one", dut_word(), word_of(0, 0, 1, 2, 3, 4, 1));
      Step = 1'b0;
      cycle("step_rel");
      En = 1'b1;
      for (int k = 0; k < 12; k++) begin
         Step = k[0];
         cycle("step_while_en");
      end
      Step = 1'b1;
      cycle("step_en_high");
      En = 1'b0;
      cycles("step_en_fall", 3);
      Step = 1'b0;
      cycle("step_low");
      Step = 1'b1;
      cycle("step_pulse2");
      Step = 1'b0;

      // 5: Load colliding with a tick
      En = 1'b1; Load = 1'b1;
      cycle("load");
      Load = 1'b0;
      cycles("load_cnt", 3);
      Load = 1'b1;
      cycle("load_on_tick");
      check("load_tick_const", dut_word(), word_of(0, 1, 2, 3, 4, 0, 0));
      Load = 1'b0;
      cycles("after_load", 3);
      check("after_load_hold", dut_word(), word_of(0, 1, 2, 3, 4, 0, 0));
      cycle("after_load_shift");
      check("after_load_shift_c", dut_word(), word_of(0, 0, 1, 2, 3, 4, 1));

      // 6: reset mid-scroll, then resume
      cycles("mid", 6);
      async_reset("rst_mid");
      En = 1'b1; Dir = 1'b0;
      cycles("resume_wait", 3);
      check("resume_hold", dut_word(), word_of(0, 1, 2, 3, 4, 0, 0));
      cycle("resume");
      check("resume_shift", dut_word(), word_of(0, 0, 1, 2, 3, 4, 1));

      // Random mix; Dir changes freely between advances
      for (int k = 0; k < 300; k++) begin
         En   = ($urandom_range(0, 3) != 0);
         Dir  = $urandom_range(0, 1);
         Step = $urandom_range(0, 1);
         Load = ($urandom_range(0, 24) == 0);
         cycle("rand");
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
